vcache_stat_collector: RTL and testbench

- Synthesizable, multi-channel successor to the per-cache testbench profiler.
- Keeps saturating event counters for `num_cache_p` vcache channels:
  - loads
  - stores
  - load misses
  - store misses
  - miss-handler busy cycles
- On a tagged snapshot request, freezes all counters into a shadow bank and drains it word-by-word over a valid/yumi stream.
- Sits beside the vcache array; its stream feeds a host-visible stat FIFO, replacing file dumps.

---
 rtl/vcache_stat_collector.sv | 186 ++++++++++++++++++
 tb/tb_vcache_stat_collector.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcache_stat_collector.sv
//==============================================================================
// Module      : vcache_stat_collector
// Description : Per-channel saturating event counters for a vcache array.
//               A tagged snapshot request freezes every counter into a shadow
//               bank, which is then drained one word per accepted transfer
//               over a valid/yumi stream in ascending (cache, event) order.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vcache_stat_collector #(
    parameter int num_cache_p     = 4,
    parameter int ctr_width_p     = 32,
    parameter int tag_width_p     = 32,
    parameter int clear_on_snap_p = 0,
    localparam int c_id_w         = (num_cache_p > 1) ? $clog2(num_cache_p) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [num_cache_p-1:0] inc_ld_i,
    input  logic [num_cache_p-1:0] inc_st_i,
    input  logic [num_cache_p-1:0] inc_ld_miss_i,
    input  logic [num_cache_p-1:0] inc_st_miss_i,
    input  logic [num_cache_p-1:0] miss_busy_i,
    input  logic                   snap_v_i,
    input  logic [tag_width_p-1:0] snap_tag_i,
    output logic                   snap_ready_o,
    output logic                   v_o,
    output logic [ctr_width_p-1:0] data_o,
    output logic [c_id_w-1:0]      cache_id_o,
    output logic [2:0]             event_id_o,
    output logic [tag_width_p-1:0] tag_o,
    output logic                   last_o,
    input  logic                   yumi_i
);

    localparam int                     c_num_ev  = 5;
    localparam logic [2:0]             c_last_ev = 3'd4;
    localparam logic [c_id_w-1:0]      c_last_ch = c_id_w'(num_cache_p - 1);
    localparam logic [c_id_w-1:0]      c_ch_one  = c_id_w'(1);
    localparam logic [ctr_width_p-1:0] c_sat     = {ctr_width_p{1'b1}};
    localparam logic [ctr_width_p-1:0] c_one     = ctr_width_p'(1);
    localparam logic [ctr_width_p-1:0] c_zero    = {ctr_width_p{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                   r_state;
    logic                     r_ready;
    logic                     r_v;
    logic                     r_last;
    logic [ctr_width_p-1:0]   r_data;
    logic [c_id_w-1:0]        r_cache;
    logic [2:0]               r_event;
    logic [tag_width_p-1:0]   r_tag;

    logic [c_num_ev-1:0]      w_inc  [num_cache_p];
    logic [ctr_width_p-1:0]   w_live [num_cache_p][c_num_ev];
    logic [ctr_width_p-1:0]   r_shadow [num_cache_p][c_num_ev];

    logic                     w_snap_accept;
    logic                     w_last_word;
    logic [c_id_w-1:0]        w_next_cache;
    logic [2:0]               w_next_event;
    logic                     w_next_last;

    // Snapshots are only taken from IDLE; requests during a drain are dropped.
    assign w_snap_accept = (r_state == ST_IDLE) && snap_v_i;
    assign w_last_word   = (r_cache == c_last_ch) && (r_event == c_last_ev);

    // Drain index walks events 0..4 within a channel, then steps the channel.
    always_comb begin
        w_next_cache = r_cache;
        w_next_event = r_event + 3'd1;
        if (r_event == c_last_ev) begin
            w_next_cache = r_cache + c_ch_one;
            w_next_event = 3'd0;
        end
        w_next_last = (w_next_cache == c_last_ch) && (w_next_event == c_last_ev);
    end

    generate
        for (genvar c = 0; c < num_cache_p; c++) begin : g_ch
            // Event order matches event_id_o: ld, st, ld_miss, st_miss, miss_cycles.
            assign w_inc[c] = {miss_busy_i[c], inc_st_miss_i[c], inc_ld_miss_i[c],
                               inc_st_i[c], inc_ld_i[c]};

            for (genvar e = 0; e < c_num_ev; e++) begin : g_ev
                logic [ctr_width_p-1:0] r_cnt;

                // Saturating event counter; optionally restarts at the snapshot edge,
                // keeping that cycle's own event so nothing is lost or counted twice.
                always_ff @(posedge clk_i) begin
                    if (reset_i) begin
                        r_cnt <= c_zero;
                    end else if (w_snap_accept && (clear_on_snap_p != 0)) begin
                        r_cnt <= w_inc[c][e] ? c_one : c_zero;
                    end else if (w_inc[c][e] && (r_cnt != c_sat)) begin
                        r_cnt <= r_cnt + c_one;
                    end
                end

                assign w_live[c][e] = r_cnt;
            end
        end
    endgenerate

    // Shadow bank captures pre-edge live values when a snapshot is accepted.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int c = 0; c < num_cache_p; c++) begin
                for (int e = 0; e < c_num_ev; e++) begin
                    r_shadow[c][e] <= c_zero;
                end
            end
        end else if (w_snap_accept) begin
            for (int c = 0; c < num_cache_p; c++) begin
                for (int e = 0; e < c_num_ev; e++) begin
                    r_shadow[c][e] <= w_live[c][e];
                end
            end
        end
    end

    // Snapshot/drain controller with registered stream outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_v     <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= c_zero;
            r_cache <= '0;
            r_event <= 3'd0;
            r_tag   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (snap_v_i) begin
                        r_state <= ST_DRAIN;
                        r_ready <= 1'b0;
                        r_v     <= 1'b1;
                        r_cache <= '0;
                        r_event <= 3'd0;
                        r_tag   <= snap_tag_i;
                        // First word is the pre-edge value of counter (0,0),
                        // identical to what the shadow bank is capturing.
                        r_data  <= w_live[0][0];
                        r_last  <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (yumi_i) begin
                        if (w_last_word) begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                            r_v     <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_cache <= w_next_cache;
                            r_event <= w_next_event;
                            r_data  <= r_shadow[w_next_cache][w_next_event];
                            r_last  <= w_next_last;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign snap_ready_o = r_ready;
    assign v_o          = r_v;
    assign data_o       = r_data;
    assign cache_id_o   = r_cache;
    assign event_id_o   = r_event;
    assign tag_o        = r_tag;
    assign last_o       = r_last;

endmodule

`default_nettype wire

// File: tb/tb_vcache_stat_collector.sv
//==============================================================================
// Module      : tb_vcache_stat_collector
// Description : Self-checking bench for vcache_stat_collector. Three instances
//               (default, 4-bit counters, clear-on-snapshot) share stimulus;
//               a reference model fills a scoreboard queue at each snapshot.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vcache_stat_collector;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] inc_ld = '0, inc_st = '0, inc_ld_miss = '0, inc_st_miss = '0, miss_busy = '0;
    logic         snap_v = 1'b0;
    logic [31:0]  snap_tag = '0;
    logic         yumi = 1'b0;

    logic        ready_a, v_a, last_a, ready_b, v_b, last_b, ready_c, v_c, last_c;
    logic [31:0] data_a, data_c, tag_a, tag_b, tag_c;
    logic [3:0]  data_b;
    logic [1:0]  cid_a, cid_b, cid_c;
    logic [2:0]  eid_a, eid_b, eid_c;

    always #5 clk = ~clk;

    vcache_stat_collector #(.num_cache_p(N), .ctr_width_p(32), .tag_width_p(32), .clear_on_snap_p(0)) u_a (
        .clk_i(clk), .reset_i(reset), .inc_ld_i(inc_ld), .inc_st_i(inc_st),
        .inc_ld_miss_i(inc_ld_miss), .inc_st_miss_i(inc_st_miss), .miss_busy_i(miss_busy),
        .snap_v_i(snap_v), .snap_tag_i(snap_tag), .snap_ready_o(ready_a), .v_o(v_a),
        .data_o(data_a), .cache_id_o(cid_a), .event_id_o(eid_a), .tag_o(tag_a),
        .last_o(last_a), .yumi_i(yumi));

    vcache_stat_collector #(.num_cache_p(N), .ctr_width_p(4), .tag_width_p(32), .clear_on_snap_p(0)) u_b (
        .clk_i(clk), .reset_i(reset), .inc_ld_i(inc_ld), .inc_st_i(inc_st),
        .inc_ld_miss_i(inc_ld_miss), .inc_st_miss_i(inc_st_miss), .miss_busy_i(miss_busy),
        .snap_v_i(snap_v), .snap_tag_i(snap_tag), .snap_ready_o(ready_b), .v_o(v_b),
        .data_o(data_b), .cache_id_o(cid_b), .event_id_o(eid_b), .tag_o(tag_b),
        .last_o(last_b), .yumi_i(yumi));

    vcache_stat_collector #(.num_cache_p(N), .ctr_width_p(32), .tag_width_p(32), .clear_on_snap_p(1)) u_c (
        .clk_i(clk), .reset_i(reset), .inc_ld_i(inc_ld), .inc_st_i(inc_st),
        .inc_ld_miss_i(inc_ld_miss), .inc_st_miss_i(inc_st_miss), .miss_busy_i(miss_busy),
        .snap_v_i(snap_v), .snap_tag_i(snap_tag), .snap_ready_o(ready_c), .v_o(v_c),
        .data_o(data_c), .cache_id_o(cid_c), .event_id_o(eid_c), .tag_o(tag_c),
        .last_o(last_c), .yumi_i(yumi));

    typedef struct {
        logic [31:0] d0, d1, d2;
        logic [1:0]  c;
        logic [2:0]  e;
        logic [31:0] tag;
        logic        last;
    } word_t;

    typedef struct {
        int          ch;
        logic [4:0]  mask;
        int          cycles;
        bit          snap;
        logic [31:0] tag;
        int          p0c, p0e;
        logic [31:0] p0a, p0b, p0cc;
        int          p1c, p1e;
        logic [31:0] p1a, p1b, p1cc;
    } vec_t;

    word_t       sb_q[$];
    logic [31:0] m_live [3][N][5];
    bit          m_busy = 0;
    int          m_rem = 0;
    bit          chk_en = 0;
    bit          yumi_en = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          probe_c [2] = '{-1, -1};
    int          probe_e [2] = '{-1, -1};
    logic [31:0] probe_x [2][3];

    // Consumer must never take a word that is not offered.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(yumi && !v_a)) else $error("FAIL yumi_protocol: yumi=%0b v=%0b", yumi, v_a);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic ev_bit(input int c, input int e);
        case (e)
            0:       return inc_ld[c];
            1:       return inc_st[c];
            2:       return inc_ld_miss[c];
            3:       return inc_st_miss[c];
            default: return miss_busy[c];
        endcase
    endfunction

    // Reference behaviour evaluated at each rising edge with the applied inputs.
    task automatic model_step();
        bit    acc = 0;
        word_t w;
        if (reset) begin
            for (int d = 0; d < 3; d++)
                for (int c = 0; c < N; c++)
                    for (int e = 0; e < 5; e++) m_live[d][c][e] = '0;
            sb_q.delete();
            m_busy = 0;
            m_rem  = 0;
            return;
        end
        if (m_busy && yumi) begin
            if (sb_q.size() > 0) w = sb_q.pop_front();
            m_rem--;
            if (m_rem == 0) m_busy = 0;
        end else if (!m_busy && snap_v) begin
            acc = 1;
            for (int c = 0; c < N; c++) begin
                for (int e = 0; e < 5; e++) begin
                    w.d0 = m_live[0][c][e]; w.d1 = m_live[1][c][e]; w.d2 = m_live[2][c][e];
                    w.c = 2'(c); w.e = 3'(e); w.tag = snap_tag;
                    w.last = (c == N - 1) && (e == 4);
                    sb_q.push_back(w);
                end
            end
            m_busy = 1;
            m_rem  = 5 * N;
        end
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < N; c++) begin
                for (int e = 0; e < 5; e++) begin
                    logic [31:0] mx;
                    mx = (d == 1) ? 32'hF : 32'hFFFF_FFFF;
                    if (d == 2 && acc) m_live[d][c][e] = ev_bit(c, e) ? 32'd1 : 32'd0;
                    else if (ev_bit(c, e) && m_live[d][c][e] != mx) m_live[d][c][e]++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        word_t w;
        if (!chk_en) return;
        chk("v_a", {31'b0, v_a}, {31'b0, m_busy});
        chk("v_b", {31'b0, v_b}, {31'b0, m_busy});
        chk("v_c", {31'b0, v_c}, {31'b0, m_busy});
        chk("ready_a", {31'b0, ready_a}, {31'b0, !m_busy});
        chk("ready_c", {31'b0, ready_c}, {31'b0, !m_busy});
        if (m_busy) begin
            if (sb_q.size() == 0) begin
                chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
                w = sb_q[0];
                chk("data_a", data_a, w.d0);
                chk("data_b", {28'b0, data_b}, w.d1);
                chk("data_c", data_c, w.d2);
                chk("cache_id_a", {30'b0, cid_a}, {30'b0, w.c});
                chk("event_id_a", {29'b0, eid_a}, {29'b0, w.e});
                chk("event_id_c", {29'b0, eid_c}, {29'b0, w.e});
                chk("tag_a", tag_a, w.tag);
                chk("last_a", {31'b0, last_a}, {31'b0, w.last});
                chk("last_b", {31'b0, last_b}, {31'b0, w.last});
                for (int p = 0; p < 2; p++) begin
                    if (int'(w.c) == probe_c[p] && int'(w.e) == probe_e[p]) begin
                        chk("probe_a", data_a, probe_x[p][0]);
                        chk("probe_b", {28'b0, data_b}, probe_x[p][1]);
                        chk("probe_c", data_c, probe_x[p][2]);
                    end
                end
            end
        end
    endtask

    // One clock: model at the rising edge, compare and drive at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        yumi = yumi_en && v_a;
    endtask

    task automatic set_probe(input int p, input int c, input int e,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] cc);
        probe_c[p] = c; probe_e[p] = e;
        probe_x[p][0] = a; probe_x[p][1] = b; probe_x[p][2] = cc;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (!(ready_a === 1'b1 && !m_busy) && cycles < 200) begin
            tick();
            cycles++;
        end
        chk("drain_done", {31'b0, ready_a}, 32'd1);
    endtask

    // Request a snapshot, drain it, and return request-to-ready cycle count.
    task automatic do_snap(input logic [31:0] tag, output int spacing);
        int n;
        snap_v = 1'b1;
        snap_tag = tag;
        tick();
        snap_v = 1'b0;
        wait_idle(n);
        spacing = n + 1;
    endtask

    task automatic drive_ev(input int ch, input logic [4:0] mask);
        inc_ld      = mask[0] ? (4'd1 << ch) : 4'd0;
        inc_st      = mask[1] ? (4'd1 << ch) : 4'd0;
        inc_ld_miss = mask[2] ? (4'd1 << ch) : 4'd0;
        inc_st_miss = mask[3] ? (4'd1 << ch) : 4'd0;
        miss_busy   = mask[4] ? (4'd1 << ch) : 4'd0;
    endtask

    vec_t vecs [5];

    initial begin
        int sp;
        vecs[0] = '{0, 5'b00000,  0, 1, 32'hA5, 3, 4, 0, 0, 0,   0, 0, 0, 0, 0};
        vecs[1] = '{2, 5'b00001,  7, 0, 32'h0,  -1, -1, 0, 0, 0, -1, -1, 0, 0, 0};
        vecs[2] = '{2, 5'b00100,  3, 0, 32'h0,  -1, -1, 0, 0, 0, -1, -1, 0, 0, 0};
        vecs[3] = '{2, 5'b10000, 40, 1, 32'h11, 2, 4, 40, 15, 40, 2, 0, 7, 7, 7};
        vecs[4] = '{0, 5'b00010, 20, 1, 32'h22, 0, 1, 20, 15, 20, 2, 0, 7, 7, 0};

        // Reset and check idle output values.
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        chk_en = 1;
        chk("rst_v_a", {31'b0, v_a}, 32'd0);
        chk("rst_last_a", {31'b0, last_a}, 32'd0);
        chk("rst_ready_a", {31'b0, ready_a}, 32'd1);
        chk("rst_data_a", data_a, 32'd0);
        chk("rst_cid_a", {30'b0, cid_a}, 32'd0);
        chk("rst_eid_a", {29'b0, eid_a}, 32'd0);
        chk("rst_tag_a", tag_a, 32'd0);
        chk("rst_ready_b", {31'b0, ready_b}, 32'd1);
        chk("rst_data_c", data_c, 32'd0);

        // Table-driven event bursts followed by full-rate snapshots.
        yumi_en = 1;
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vecs[v].cycles; i++) begin
                drive_ev(vecs[v].ch, vecs[v].mask);
                tick();
            end
            drive_ev(0, 5'b0);
            if (vecs[v].snap) begin
                set_probe(0, vecs[v].p0c, vecs[v].p0e, vecs[v].p0a, vecs[v].p0b, vecs[v].p0cc);
                set_probe(1, vecs[v].p1c, vecs[v].p1e, vecs[v].p1a, vecs[v].p1b, vecs[v].p1cc);
                do_snap(vecs[v].tag, sp);
                chk("snap_spacing", sp, 32'd21);
            end
        end

        // Events in the snapshot cycle belong to the next snapshot.
        inc_ld = 4'b0010;
        for (int i = 0; i < 5; i++) tick();
        set_probe(0, 1, 0, 5, 5, 5);
        set_probe(1, 0, 1, 20, 15, 0);
        snap_v = 1'b1;
        snap_tag = 32'h33;
        tick();
        snap_v = 1'b0;
        tick();
        tick();
        inc_ld = 4'b0000;
        wait_idle(sp);
        set_probe(0, 1, 0, 8, 8, 3);
        do_snap(32'h44, sp);

        // Stalled drain: outputs hold, extra request ignored, counting goes on.
        yumi_en = 0;
        set_probe(0, 1, 0, 8, 8, 0);
        set_probe(1, 3, 3, 0, 0, 0);
        snap_v = 1'b1;
        snap_tag = 32'h55;
        tick();
        snap_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin snap_v = 1'b1; snap_tag = 32'h66; end
            if (i >= 5 && i <= 8) inc_st_miss = 4'b1000;
            tick();
            snap_v = 1'b0;
            inc_st_miss = 4'b0000;
            chk("stall_ready", {31'b0, ready_a}, 32'd0);
            chk("stall_cid", {30'b0, cid_a}, 32'd0);
        end
        yumi_en = 1;
        wait_idle(sp);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_queued_snap", {31'b0, v_a}, 32'd0);
        end
        set_probe(0, 3, 3, 4, 4, 4);
        set_probe(1, 1, 0, 8, 8, 0);
        do_snap(32'h77, sp);

        // Reset after six of twenty words.
        snap_v = 1'b1;
        snap_tag = 32'h88;
        tick();
        snap_v = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("mid_cid", {30'b0, cid_a}, 32'd1);
        chk("mid_eid", {29'b0, eid_a}, 32'd1);
        reset = 1'b1;
        tick();
        chk("rst_mid_v", {31'b0, v_a}, 32'd0);
        chk("rst_mid_ready", {31'b0, ready_a}, 32'd1);
        reset = 1'b0;
        set_probe(0, 3, 3, 0, 0, 0);
        set_probe(1, 1, 0, 0, 0, 0);
        do_snap(32'h99, sp);
        chk("post_rst_spacing", sp, 32'd21);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
